// File: rtl/line_tap_buffer.sv
// line_tap_buffer: multi-tap row delay line that outputs N_TAPS vertically aligned samples per accepted beat
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_clr, i_len        sync clear; loads row length (0 or >MAX_LEN clamps to MAX_LEN)
//   i_valid, i_data     input beat
//   o_valid             one-cycle pulse when outputs were updated from a beat
//   o_taps              tap k in bits [k*N_DATA +: N_DATA], tap 0 = newest sample
//   o_tap_vld           bit k set once tap k carries real data
module line_tap_buffer #(
  parameter int N_DATA = 32,
  parameter int MAX_LEN = 32,
  parameter int N_TAPS = 3,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic [LW-1:0]            i_len,
  input  logic                     i_valid,
  input  logic [N_DATA-1:0]        i_data,
  output logic                     o_valid,
  output logic [N_TAPS*N_DATA-1:0] o_taps,
  output logic [N_TAPS-1:0]        o_tap_vld
);
  localparam int PW = $clog2(MAX_LEN);
  localparam int NL = N_TAPS - 1;
  localparam int FW = $clog2(NL * MAX_LEN + 1);
  logic [N_DATA-1:0]        line_mem [NL][MAX_LEN];
  logic [N_DATA-1:0]        old_data [NL];
  logic                     accept;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [FW-1:0]            fill_q, fill_d;
  logic [LW-1:0]            len_q, len_d;
  logic                     valid_q, valid_d;
  logic [N_TAPS*N_DATA-1:0] taps_q, taps_d;
  logic [N_TAPS-1:0]        tap_vld_q, tap_vld_d;
  always_comb begin
    accept = i_valid && !i_clr;
    for (int j = 0; j < NL; j++) old_data[j] = line_mem[j][ptr_q];
    len_d = len_q;
    if (i_clr) len_d = (i_len == '0 || i_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : i_len;
    // pointer is widened to LW before comparing so len_q-1 never overflows it
    ptr_d = i_clr ? '0 : !accept ? ptr_q : (LW'(ptr_q) == len_q - LW'(1)) ? '0 : ptr_q + PW'(1);
    fill_d = i_clr ? '0 : (accept && int'(fill_q) < NL * int'(len_q)) ? fill_q + FW'(1) : fill_q;
    valid_d = accept;
    taps_d = taps_q;
    tap_vld_d = i_clr ? '0 : tap_vld_q;
    if (accept) begin
      taps_d[N_DATA-1:0] = i_data;
      for (int k = 1; k < N_TAPS; k++) taps_d[k*N_DATA +: N_DATA] = old_data[k-1];
      for (int k = 0; k < N_TAPS; k++) tap_vld_d[k] = int'(fill_q) >= k * int'(len_q);
    end
  end
  // each line is read before write at the shared pointer, so line j feeds line j+1 one row later
  always_ff @(posedge i_clk) begin
    if (accept) begin
      line_mem[0][ptr_q] <= i_data;
      for (int j = 1; j < NL; j++) line_mem[j][ptr_q] <= old_data[j-1];
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q     <= '0;
      fill_q    <= '0;
      len_q     <= LW'(MAX_LEN);
      valid_q   <= 1'b0;
      taps_q    <= '0;
      tap_vld_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      fill_q    <= fill_d;
      len_q     <= len_d;
      valid_q   <= valid_d;
      taps_q    <= taps_d;
      tap_vld_q <= tap_vld_d;
    end
  end
  assign o_valid   = valid_q;
  assign o_taps    = taps_q;
  assign o_tap_vld = tap_vld_q;
endmodule

// File: tb/tb_line_tap_buffer.sv
// tb_line_tap_buffer: scoreboard bench for line_tap_buffer
module tb_line_tap_buffer;
  localparam int ND = 8;
  localparam int ML = 8;
  localparam int NT = 3;
  localparam int LW = $clog2(ML + 1);
  typedef struct {
    logic [NT*ND-1:0] taps;
    logic [NT*ND-1:0] mask;
    logic [NT-1:0]    vld;
  } exp_t;
  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b1;
  logic             i_clr = 1'b0;
  logic [LW-1:0]    i_len = '0;
  logic             i_valid = 1'b0;
  logic [ND-1:0]    i_data = '0;
  logic             o_valid;
  logic [NT*ND-1:0] o_taps;
  logic [NT-1:0]    o_tap_vld;
  exp_t             sb[$];
  exp_t             me;
  int               hist[$];
  int               mlen = ML;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               pulses = 0;
  logic [NT*ND-1:0] last_taps = '0;

  line_tap_buffer #(.N_DATA(ND), .MAX_LEN(ML), .N_TAPS(NT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .i_len(i_len),
    .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_taps(o_taps), .o_tap_vld(o_tap_vld)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic clr, input int len, input logic v, input int d);
    @(posedge i_clk);
    #1;
    i_clr = clr;
    i_len = LW'(len);
    i_valid = v;
    i_data = ND'(d);
    if (clr) begin
      mlen = (len == 0 || len > ML) ? ML : len;
      hist.delete();
    end else if (v) begin
      exp_t e;
      int n;
      n = hist.size();
      hist.push_back(d);
      e.taps = '0;
      e.mask = '0;
      e.vld = '0;
      for (int k = 0; k < NT; k++)
        if (n >= k * mlen) begin
          e.vld[k] = 1'b1;
          e.taps[k*ND +: ND] = ND'(hist[n - k * mlen]);
          e.mask[k*ND +: ND] = '1;
        end
      sb.push_back(e);
    end
  endtask

  task automatic stream(input int base, input int n, input bit gap, input int len);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, len, 1'b1, base + i);
      if (gap) drive(1'b0, len, 1'b0, 0);
    end
  endtask

  task automatic drain(input string tag);
    repeat (3) drive(1'b0, 0, 1'b0, 0);
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    forever begin
      @(negedge i_clk);
      if (o_valid) begin
        pulses++;
        if (sb.size() == 0) check("spurious_valid", 64'd1, 64'd0);
        else begin
          me = sb.pop_front();
          check("tap_vld", 64'(o_tap_vld), 64'(me.vld));
          check("taps", 64'(o_taps & me.mask), 64'(me.taps));
        end
      end else if (i_rst_n) check("hold", 64'(o_taps), 64'(last_taps));
      last_taps = o_taps;
    end
  end

  initial begin
    #1 i_rst_n = 1'b0;
    #22 i_rst_n = 1'b1;
    repeat (10) begin
      @(negedge i_clk);
      check("idle", 64'({o_valid, o_tap_vld, o_taps}), 64'd0);
    end
    drive(1'b1, 4, 1'b0, 0);
    pulses = 0;
    stream(0, 12, 1'b0, 4);
    drain("fill_drain");
    check("fill_pulses", 64'(pulses), 64'd12);
    drive(1'b1, 4, 1'b0, 0);
    pulses = 0;
    stream(0, 12, 1'b1, 4);
    drain("gap_drain");
    check("gap_pulses", 64'(pulses), 64'd12);
    drive(1'b1, 0, 1'b0, 0);
    stream(100, 10, 1'b0, 0);
    drain("len0_drain");
    drive(1'b1, 2, 1'b0, 0);
    stream(20, 8, 1'b0, 2);
    stream(28, 6, 1'b0, 5);
    drain("len2_drain");
    drive(1'b1, 2, 1'b1, 99);
    drive(1'b0, 2, 1'b0, 0);
    @(negedge i_clk);
    check("clr_tap_vld", 64'(o_tap_vld), 64'd0);
    check("clr_valid", 64'(o_valid), 64'd0);
    stream(40, 6, 1'b0, 2);
    drain("clr_drain");
    stream(50, 5, 1'b0, 2);
    #2 i_rst_n = 1'b0;
    sb.delete();
    hist.delete();
    mlen = ML;
    #1 check("rst_zero", 64'({o_valid, o_tap_vld, o_taps}), 64'd0);
    i_valid = 1'b0;
    i_clr = 1'b0;
    #20 i_rst_n = 1'b1;
    stream(60, 10, 1'b0, 0);
    drain("rst_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/line_tap_buffer.md
Name: line_tap_buffer

Overview:
- Parametrised, multi-tap delay-line buffer; successor to the fixed-length, single-output shift RAM used in front of the maxpooler.
- Delivers N_TAPS vertically aligned samples per accepted beat (current row plus N_TAPS-1 previous rows) for KxK pooling/convolution windows.
- Row length is set at runtime, up to MAX_LEN. Input is valid-qualified; per-tap fill status is reported.

Parameters:
- N_DATA, 32, sample width in bits.
- MAX_LEN, 32, maximum row length (delay per tap), >= 2.
- N_TAPS, 3, number of output taps (tap 0 = current sample), >= 2.
- LW, $clog2(MAX_LEN+1), width of the length input; derived, not overridden.

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_clr  in  1  synchronous clear; also loads i_len.
- i_len  in  LW  row length, sampled only on i_clr.
- i_valid  in  1  i_data accepted this cycle.
- i_data  in  N_DATA  input sample.
- o_valid  out  1  one-cycle pulse: outputs updated from an accepted beat.
- o_taps  out  N_TAPS*N_DATA  tap k in bits [k*N_DATA +: N_DATA].
- o_tap_vld  out  N_TAPS  bit k = tap k holds real (not pre-fill) data.

Behaviour:
- Reset (async assert, i_rst_n=0):
  - o_valid=0, o_taps=0, o_tap_vld=0.
  - Write pointer=0, fill counter=0, len_q=MAX_LEN.
  - Buffer RAM contents are don't-care.
- len_q load:
  - Loaded from i_len on any cycle with i_clr=1.
  - i_len=0 or i_len>MAX_LEN loads MAX_LEN (clamp).
  - i_len=1 is legal: each tap is one beat older than the previous.
- i_clr effect, on the next edge:
  - Pointer=0, fill=0, o_tap_vld=0, o_valid=0.
  - o_taps is held; RAM is not cleared.
  - i_clr and i_valid in the same cycle: clear wins, the beat is dropped.
- Storage and write pointer:
  - N_TAPS-1 circular line memories, MAX_LEN deep each.
  - One shared write pointer wraps from len_q-1 back to 0.
- Accepted beat (i_valid=1, i_clr=0), at address ptr:
  - Read line j (read-before-write): old_j.
  - Write line 0 <= i_data; write line j <= old_(j-1) for j>=1.
  - Next edge: o_taps tap 0 <= i_data; tap k <= old_(k-1) for k>=1.
  - Next edge: o_valid <= 1; ptr advances with wrap.
- Latency: outputs appear 1 cycle after acceptance.
- Tap k content: the sample accepted exactly k*len_q beats earlier.
- No i_valid: o_valid=0; o_taps and o_tap_vld hold. Outputs are never forced to zero.
- Fill counter:
  - Counts accepted beats since reset/clr.
  - Saturates at (N_TAPS-1)*len_q; does not wrap.
- o_tap_vld:
  - Registered alongside o_taps.
  - Bit k = 1 iff fill before this beat >= k*len_q.
  - Bit 0 = 1 after the first accepted beat.
- Back-to-back i_valid every cycle is supported with no bubbles; the block never stalls.
- Changing i_len without i_clr has no effect.
- Async reset mid-stream aborts immediately; the block restarts empty.
- Arithmetic:
  - Pointer is $clog2(MAX_LEN) bits.
  - Fill counter is wide enough for (N_TAPS-1)*MAX_LEN.
  - Pointer compare is against len_q-1 with no overflow.
- Memories may infer as distributed or block RAM, but read data must be available in the same cycle (async read) or the design pipelined internally. Either way, external latency stays exactly 1.

Test Plan:
- Reset, then idle: N_DATA=8, MAX_LEN=8, N_TAPS=3. Required: o_valid=0, o_taps=0, o_tap_vld=000 for 10 cycles.
- Basic fill: i_clr with i_len=4, then stream 0..11 continuously.
  - At beat n: tap0=n.
  - tap1=n-4, vld[1]=1 from n=4.
  - tap2=n-8, vld[2]=1 from n=8.
  - o_valid pulses 12 times, each 1 cycle after its beat.
- Gapped input: same stream with i_valid toggling 1,0,1,0.
  - Tap values identical to the basic-fill test.
  - Outputs hold during gaps; o_valid=0 in gap cycles.
- Length reload/clamp:
  - i_clr with i_len=0: len_q=8, tap1 valid from beat 8.
  - i_clr with i_len=2: tap1=n-2, tap2=n-4.
  - i_len change without i_clr: no effect.
- Clear collision: i_clr and i_valid together mid-stream. Required: that beat is dropped, o_tap_vld=000, the next beat is treated as beat 0.
- Async reset mid-stream: assert i_rst_n=0 between edges. Required: outputs zero immediately; after release, len_q=MAX_LEN and fill restarts from 0.
